// File: rtl/nios_system_onchip_memory_pipelined_if.sv
// Avalon-MM slave bundle for the pipelined on-chip RAM.
// Parity signals exist only when ONCHIP_MEM_PARITY_EN is defined.
interface nios_system_onchip_memory_pipelined_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 14
);
   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                chipselect;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;
   logic                waitrequest;
`ifdef ONCHIP_MEM_PARITY_EN
   logic                parity_inject;
   logic                parity_err;
`endif

   modport master (
      output address, byteenable, chipselect, read, write, writedata,
`ifdef ONCHIP_MEM_PARITY_EN
      output parity_inject,
      input  parity_err,
`endif
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, byteenable, chipselect, read, write, writedata,
`ifdef ONCHIP_MEM_PARITY_EN
      input  parity_inject,
      output parity_err,
`endif
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/nios_system_onchip_memory_pipelined.sv
// Avalon-MM on-chip RAM: byte-enabled writes, 1/2-cycle pipelined reads, power-up clear engine.
// Define ONCHIP_MEM_PARITY_EN to add one even-parity bit per byte with error reporting.
module nios_system_onchip_memory_pipelined #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 14,
   parameter int DEPTH          = 12288,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clken,
   output logic clear_busy,
   nios_system_onchip_memory_pipelined_if.slave bus
);
   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef ONCHIP_MEM_PARITY_EN
   localparam int MEM_W = DATA_W + NB;
`else
   localparam int MEM_W = DATA_W;
`endif
   localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [1:0] {ST_RST, ST_CLEAR, ST_RUN} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] clr_idx;
   logic             clear_we;
   logic             waitrequest;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_RST;
      else          state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RST:   state_nxt = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         ST_CLEAR: if (clken && clr_idx == LAST_IDX) state_nxt = ST_RUN;
         default:  state_nxt = state;
      endcase
   end

   always_comb begin
      waitrequest = 1'b1;
      clear_busy  = 1'b0;
      clear_we    = 1'b0;
      case (state)
         ST_CLEAR: begin
            clear_busy = 1'b1;
            clear_we   = clken;
         end
         ST_RUN:   waitrequest = ~clken;
         default:  waitrequest = 1'b1;
      endcase
   end

   assign bus.waitrequest = waitrequest;

   // An abort mid-clear resets the index, so the next clear starts from word 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      clr_idx <= '0;
      else if (clear_we) clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + 1'b1;
   end

   logic             in_range, wr_acc, rd_acc;
   logic [IDX_W-1:0] idx;

   assign in_range = {1'b0, bus.address} < DEPTH_A;
   assign idx      = bus.address[IDX_W-1:0];
   assign wr_acc   = bus.chipselect & bus.write & ~waitrequest;
   assign rd_acc   = bus.chipselect & bus.read & ~bus.write & ~waitrequest;

   // Single write port shared by the clear engine and the bus.
   logic [NB-1:0]    lane_we;
   logic [MEM_W-1:0] wr_word;
   logic [IDX_W-1:0] wr_idx;

   always_comb begin
      lane_we = '0;
      wr_word = '0;
      wr_idx  = clr_idx;
      if (clear_we) begin
         lane_we = '1;
      end else if (wr_acc && in_range) begin
         lane_we                = bus.byteenable;
         wr_idx                 = idx;
         wr_word[DATA_W-1:0]    = bus.writedata;
`ifdef ONCHIP_MEM_PARITY_EN
         for (int i = 0; i < NB; i++)
            wr_word[DATA_W+i] = (^bus.writedata[8*i +: 8]) ^ bus.parity_inject;
`endif
      end
   end

   logic [MEM_W-1:0] mem [DEPTH];

   // NOTE: the array itself is never reset; zeroing is the clear engine's job, keeping it RAM-mappable.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (lane_we[i]) begin
            mem[wr_idx][8*i +: 8] <= wr_word[8*i +: 8];
`ifdef ONCHIP_MEM_PARITY_EN
            mem[wr_idx][DATA_W+i] <= wr_word[DATA_W+i];
`endif
         end
      end
   end

   // Read pipeline: valid bits carry reset, data stages do not.
   logic [READ_LATENCY-1:0] vld_q;
   logic [MEM_W-1:0]        dat_q [READ_LATENCY];
   logic [MEM_W-1:0]        out_word;
   logic [DATA_W-1:0]       hold_q;
   logic                    rdv;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
      end else if (clken) begin
         vld_q[0] <= rd_acc;
         for (int i = 1; i < READ_LATENCY; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (clken) begin
         dat_q[0] <= (rd_acc && in_range) ? mem[idx] : '0;
         for (int i = 1; i < READ_LATENCY; i++) dat_q[i] <= dat_q[i-1];
      end
   end

   assign out_word = dat_q[READ_LATENCY-1];
   assign rdv      = vld_q[READ_LATENCY-1] & clken;

   // readdata falls back to the last delivered word whenever no valid is presented.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) hold_q <= '0;
      else if (rdv) hold_q <= out_word[DATA_W-1:0];
   end

   assign bus.readdatavalid = rdv;
   assign bus.readdata      = rdv ? out_word[DATA_W-1:0] : hold_q;

`ifdef ONCHIP_MEM_PARITY_EN
   logic [NB-1:0] par_calc;

   always_comb begin
      par_calc = '0;
      for (int i = 0; i < NB; i++) par_calc[i] = ^out_word[8*i +: 8];
   end

   assign bus.parity_err = rdv & (|(par_calc ^ out_word[MEM_W-1:DATA_W]));
`endif

endmodule

// File: tb/tb_nios_system_onchip_memory_pipelined.sv
// Directed bench for nios_system_onchip_memory_pipelined: DEPTH=16, ADDR_W=5, READ_LATENCY=2.
// Parity steps are included when ONCHIP_MEM_PARITY_EN is defined.
module tb_nios_system_onchip_memory_pipelined;
   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int DEP = 16;
   localparam int LAT = 2;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic clken   = 1'b1;
   logic clear_busy;
   int   checks  = 0;
   int   errors  = 0;
`ifdef ONCHIP_MEM_PARITY_EN
   logic inject  = 1'b0;
`endif

   always #5 clk = ~clk;

   nios_system_onchip_memory_pipelined_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   nios_system_onchip_memory_pipelined #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .clken(clken),
      .clear_busy(clear_busy),
      .bus(bus.slave)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
      bus.write      = 1'b0;
      bus.address    = '0;
      bus.byteenable = '0;
      bus.writedata  = '0;
`ifdef ONCHIP_MEM_PARITY_EN
      bus.parity_inject = 1'b0;
`endif
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
      bus.chipselect = 1'b1;
      bus.write      = 1'b1;
      bus.read       = 1'b0;
      bus.address    = a;
      bus.writedata  = d;
      bus.byteenable = be;
`ifdef ONCHIP_MEM_PARITY_EN
      bus.parity_inject = inject;
`endif
      step();
      idle();
   endtask

   // Returns in the cycle readdatavalid is seen; n = cycles from request to valid (bounded).
   task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int n);
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.write      = 1'b0;
      bus.address    = a;
      n = 0;
      do begin
         step();
         idle();
         n++;
      end while (!bus.readdatavalid && n < 12);
      d = bus.readdata;
   endtask

   task automatic count_busy(output int n, output logic wr_ok);
      int guard;
      guard = 0;
      n     = 0;
      wr_ok = 1'b1;
      do begin
         step();
         guard++;
         if (clear_busy) begin
            n++;
            if (!bus.waitrequest) wr_ok = 1'b0;
         end
      end while ((n == 0 || clear_busy) && guard < 64);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] d;
      int            n;
      logic          ok;

      idle();
      repeat (3) step();
      check("rst_rdv",   bus.readdatavalid, 1'b0);
      check("rst_wait",  bus.waitrequest,   1'b1);
      check("rst_busy",  clear_busy,        1'b0);
      check("rst_rdata", bus.readdata,      32'h0);

      reset_n = 1'b1;
      count_busy(n, ok);
      check("clear_cycles", n, 16);
      check("clear_wait",   ok, 1'b1);
      check("run_wait",     bus.waitrequest, 1'b0);

      do_read(5'd3, d, n);
      check("rd3_lat",  n, LAT);
      check("rd3_data", d, 32'h0);
      do_read(5'd15, d, n);
      check("rd15_clr", d, 32'h0);

      do_write(5'd5, 32'hDEADBEEF, 4'b0101);
      do_read(5'd5, d, n);
      check("be_lat",  n, LAT);
      check("be_data", d, 32'h00AD00EF);

      do_write(5'd0, 32'h11111111, 4'hF);
      do_write(5'd1, 32'h22222222, 4'hF);
      do_write(5'd2, 32'h33333333, 4'hF);
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.address    = 5'd0;
      step();
      check("b2b_c1_rdv", bus.readdatavalid, 1'b0);
      bus.address = 5'd1;
      step();
      check("b2b_c2_rdv", bus.readdatavalid, 1'b1);
      check("b2b_c2_dat", bus.readdata, 32'h11111111);
      bus.address = 5'd2;
      step();
      idle();
      check("b2b_c3_rdv", bus.readdatavalid, 1'b1);
      check("b2b_c3_dat", bus.readdata, 32'h22222222);
      step();
      check("b2b_c4_rdv", bus.readdatavalid, 1'b1);
      check("b2b_c4_dat", bus.readdata, 32'h33333333);
      step();
      check("b2b_c5_rdv", bus.readdatavalid, 1'b0);
      check("b2b_hold",   bus.readdata, 32'h33333333);

      do_write(5'd7, 32'hCAFEF00D, 4'hF);
      do_read(5'd7, d, n);
      check("raw_data", d, 32'hCAFEF00D);

      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.write      = 1'b1;
      bus.address    = 5'd8;
      bus.writedata  = 32'hA5A5A5A5;
      bus.byteenable = 4'hF;
      step();
      idle();
      ok = 1'b0;
      repeat (4) begin
         step();
         if (bus.readdatavalid) ok = 1'b1;
      end
      check("rw_no_valid", ok, 1'b0);
      do_read(5'd8, d, n);
      check("rw_wr_done", d, 32'hA5A5A5A5);

      do_write(5'd20, 32'h12345678, 4'hF);
      do_read(5'd20, d, n);
      check("oor_lat",  n, LAT);
      check("oor_data", d, 32'h0);
      do_read(5'd4, d, n);
      check("oor_alias", d, 32'h0);

      do_write(5'd15, 32'h0F0F0F0F, 4'hF);
      do_read(5'd15, d, n);
      check("last_word", d, 32'h0F0F0F0F);

      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.address    = 5'd5;
      step();
      idle();
      clken = 1'b0;
      ok    = 1'b1;
      repeat (3) begin
         step();
         if (bus.readdatavalid || !bus.waitrequest) ok = 1'b0;
      end
      check("stall_quiet", ok, 1'b1);
      clken = 1'b1;
      step();
      check("stall_rdv",  bus.readdatavalid, 1'b1);
      check("stall_data", bus.readdata, 32'h00AD00EF);
      step();
      check("stall_pulse", bus.readdatavalid, 1'b0);

      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.address    = 5'd7;
      step();
      idle();
      step();
      check("reemit_pre", bus.readdatavalid, 1'b1);
      clken = 1'b0;
      #1;
      check("reemit_forced", bus.readdatavalid, 1'b0);
      check("reemit_hold",   bus.readdata, 32'h00AD00EF);
      clken = 1'b1;
      #1;
      check("reemit_rdv",  bus.readdatavalid, 1'b1);
      check("reemit_data", bus.readdata, 32'hCAFEF00D);
      step();
      check("reemit_once", bus.readdatavalid, 1'b0);

`ifdef ONCHIP_MEM_PARITY_EN
      inject = 1'b1;
      do_write(5'd9, 32'h12345678, 4'hF);
      inject = 1'b0;
      do_read(5'd9, d, n);
      check("par_inj_data", d, 32'h12345678);
      check("par_inj_err",  bus.parity_err, 1'b1);
      do_write(5'd9, 32'h12345678, 4'hF);
      do_read(5'd9, d, n);
      check("par_ok_err", bus.parity_err, 1'b0);
      step();
      check("par_idle_err", bus.parity_err, 1'b0);
`endif

      do_write(5'd12, 32'hFFFFFFFF, 4'hF);
      reset_n = 1'b0;
      #1;
      check("arst_wait",  bus.waitrequest,   1'b1);
      check("arst_busy",  clear_busy,        1'b0);
      check("arst_rdata", bus.readdata,      32'h0);
      repeat (2) step();
      reset_n = 1'b1;
      repeat (8) step();
      check("mid_clear_busy", clear_busy, 1'b1);
      reset_n = 1'b0;
      #1;
      check("abort_busy", clear_busy, 1'b0);
      step();
      reset_n = 1'b1;
      count_busy(n, ok);
      check("restart_cycles", n, 16);
      do_read(5'd12, d, n);
      check("restart_rd12", d, 32'h0);
      do_read(5'd0, d, n);
      check("restart_rd0", d, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
